// File: rtl/usb_tx_arbiter_if.sv
// Byte-stream arbiter bus bundle.
//   Requester side : req_data (24 bits per requester, packed), req_valid, req_ready
//   USB side       : usb_ready, usb_data_out, usb_data_valid
//   Status         : grant_id, busy
// slave  = the arbiter's view, master = the environment driving requests / sinking bytes.
interface usb_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [24*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  usb_ready;
    logic [7:0]            usb_data_out;
    logic                  usb_data_valid;
    logic [ID_W-1:0]       grant_id;
    logic                  busy;

    modport slave (
        input  req_data, req_valid, usb_ready,
        output req_ready, usb_data_out, usb_data_valid, grant_id, busy
    );

    modport master (
        output req_data, req_valid, usb_ready,
        input  req_ready, usb_data_out, usb_data_valid, grant_id, busy
    );
endinterface

// File: rtl/usb_tx_arbiter.sv
// Round-robin arbiter sharing one USB byte output between NUM_REQ word streams.
// Each 24-bit word goes out as {4'hA, id}, data[23:16], data[15:8], data[7:0].
// A winner keeps the output for up to MAX_BURST back-to-back words.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : usb_tx_arbiter_if.slave (request inputs, byte output, grant_id, busy)
module usb_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    usb_tx_arbiter_if.slave   bus
);
    localparam int BW = $clog2(MAX_BURST) + 1;

    typedef enum logic [2:0] {IDLE, HDR, B2, B1, B0} state_t;

    state_t          state_q;
    logic [23:0]     word_q;
    logic [ID_W-1:0] grant_q;
    logic [ID_W-1:0] last_q;
    logic [BW-1:0]   burst_q;
    logic [7:0]      dout_q;
    logic            dval_q;
    logic            busy_q;

    logic [ID_W-1:0] win;
    logic            any_req;
    logic            xfer;
    logic            cont;

    // Walk from farthest to nearest so the last hit is the first requester
    // after last_q in wrap-around order.
    always_comb begin
        win = last_q;
        for (int k = NUM_REQ; k >= 1; k--) begin
            logic [ID_W-1:0] cand;
            cand = ID_W'((int'(last_q) + k) % NUM_REQ);
            if (bus.req_valid[cand]) win = cand;
        end
    end

    assign any_req = |bus.req_valid;
    assign xfer    = dval_q & bus.usb_ready;
    // Burst continuation: next word captured in the same cycle as the B0 byte leaves.
    assign cont    = (state_q == B0) && xfer && bus.req_valid[grant_q] &&
                     (burst_q < BW'(MAX_BURST - 1));

    always_comb begin
        bus.req_ready = '0;
        if (state_q == IDLE && any_req) bus.req_ready[win]     = 1'b1;
        else if (cont)                  bus.req_ready[grant_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            grant_q <= '0;
            last_q  <= ID_W'(NUM_REQ - 1);
            burst_q <= '0;
            dout_q  <= '0;
            dval_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (any_req) begin
                    word_q  <= bus.req_data[24*win +: 24];
                    grant_q <= win;
                    burst_q <= '0;
                    dout_q  <= {4'hA, 4'(win)};
                    dval_q  <= 1'b1;
                    busy_q  <= 1'b1;
                    state_q <= HDR;
                end
                HDR: if (xfer) begin
                    dout_q  <= word_q[23:16];
                    state_q <= B2;
                end
                B2: if (xfer) begin
                    dout_q  <= word_q[15:8];
                    state_q <= B1;
                end
                B1: if (xfer) begin
                    dout_q  <= word_q[7:0];
                    state_q <= B0;
                end
                B0: if (xfer) begin
                    if (cont) begin
                        word_q  <= bus.req_data[24*grant_q +: 24];
                        burst_q <= burst_q + BW'(1);
                        dout_q  <= {4'hA, 4'(grant_q)};
                        state_q <= HDR;
                    end else begin
                        last_q  <= grant_q;
                        dout_q  <= '0;
                        dval_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.usb_data_out   = dout_q;
    assign bus.usb_data_valid = dval_q;
    assign bus.grant_id       = grant_q;
    assign bus.busy           = busy_q;
endmodule

// File: tb/tb_usb_tx_arbiter.sv
module tb_usb_tx_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    usb_tx_arbiter_if #(.NUM_REQ(N)) ifa ();
    usb_tx_arbiter_if #(.NUM_REQ(N)) ifb ();

    // a: MAX_BURST=4, b: MAX_BURST=1 (pure round-robin)
    usb_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    usb_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // requester models: per-requester word FIFO, valid while non-empty
    logic [23:0] words_a [N][16];
    logic [23:0] words_b [N][16];
    int head_a[N], tail_a[N], head_b[N], tail_b[N];

    // scoreboards: {is_header, byte}
    logic [8:0] sb_a[$];
    logic [8:0] sb_b[$];
    int hcyc_a[$], hcyc_b[$], bcyc_a[$];

    always @(posedge clk) cyc++;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ifa.req_valid[i]        = (head_a[i] != tail_a[i]);
            ifa.req_data[24*i +: 24] = words_a[i][head_a[i] % 16];
            ifb.req_valid[i]        = (head_b[i] != tail_b[i]);
            ifb.req_data[24*i +: 24] = words_b[i][head_b[i] % 16];
        end
    end

    always @(posedge clk) begin
        logic [N-1:0] acc_a, acc_b;
        acc_a = ifa.req_valid & ifa.req_ready & {N{rst_n}};
        acc_b = ifb.req_valid & ifb.req_ready & {N{rst_n}};
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_a[i]) head_a[i]++;
            if (acc_b[i]) head_b[i]++;
        end
    end

    // scoreboard consumer: a byte transfers at the next posedge when valid & ready
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n) begin
            checks++;
            if ($countones(ifa.req_ready) > 1 || $countones(ifb.req_ready) > 1) begin
                failures++;
                $display("FAIL req_ready_onehot a=%b b=%b want at most one bit", ifa.req_ready, ifb.req_ready);
            end
            if (ifa.usb_data_valid && ifa.usb_ready) begin
                checks++;
                if (sb_a.size() == 0) begin
                    failures++;
                    $display("FAIL a_byte_unexpected got=%h want=none", ifa.usb_data_out);
                end else begin
                    e = sb_a.pop_front();
                    if (ifa.usb_data_out !== e[7:0]) begin
                        failures++;
                        $display("FAIL a_byte got=%h want=%h cyc=%0d", ifa.usb_data_out, e[7:0], cyc);
                    end
                    if (e[8]) hcyc_a.push_back(cyc);
                    bcyc_a.push_back(cyc);
                end
            end
            if (ifb.usb_data_valid && ifb.usb_ready) begin
                checks++;
                if (sb_b.size() == 0) begin
                    failures++;
                    $display("FAIL b_byte_unexpected got=%h want=none", ifb.usb_data_out);
                end else begin
                    e = sb_b.pop_front();
                    if (ifb.usb_data_out !== e[7:0]) begin
                        failures++;
                        $display("FAIL b_byte got=%h want=%h cyc=%0d", ifb.usb_data_out, e[7:0], cyc);
                    end
                    if (e[8]) hcyc_b.push_back(cyc);
                end
            end
        end
    end

    function automatic logic [23:0] wd(int r, int k);
        return {4'(r), 4'(k), 8'hA5 ^ 8'(r*16 + k), 8'(8'h3C + r*9 + k)};
    endfunction

    task automatic load_a(int r, logic [23:0] w);
        words_a[r][tail_a[r] % 16] = w;
        tail_a[r]++;
    endtask

    task automatic load_b(int r, logic [23:0] w);
        words_b[r][tail_b[r] % 16] = w;
        tail_b[r]++;
    endtask

    task automatic exp_a(int r, logic [23:0] w);
        sb_a.push_back({1'b1, 4'hA, 4'(r)});
        sb_a.push_back({1'b0, w[23:16]});
        sb_a.push_back({1'b0, w[15:8]});
        sb_a.push_back({1'b0, w[7:0]});
    endtask

    task automatic exp_b(int r, logic [23:0] w);
        sb_b.push_back({1'b1, 4'hA, 4'(r)});
        sb_b.push_back({1'b0, w[23:16]});
        sb_b.push_back({1'b0, w[15:8]});
        sb_b.push_back({1'b0, w[7:0]});
    endtask

    task automatic test_reset();
        ifa.usb_ready = 1'b0;
        ifb.usb_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ifa.usb_data_valid !== 1'b0 || ifa.usb_data_out !== 8'h00 || ifa.grant_id !== 2'd0 ||
            ifa.busy !== 1'b0 || ifa.req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_a got v=%b d=%h g=%0d busy=%b rdy=%b want all zero",
                     ifa.usb_data_valid, ifa.usb_data_out, ifa.grant_id, ifa.busy, ifa.req_ready);
        end
        checks++;
        if (ifb.usb_data_valid !== 1'b0 || ifb.busy !== 1'b0 || ifb.req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_b got v=%b busy=%b rdy=%b want zero", ifb.usb_data_valid, ifb.busy, ifb.req_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_word();
        int rr = 0;
        bcyc_a.delete();
        exp_a(1, 24'h123456);
        @(posedge clk); #1;
        ifa.usb_ready = 1'b1;
        load_a(1, 24'h123456);
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            rr += int'(ifa.req_ready[1]);
            if (sb_a.size() == 0 && !ifa.busy) break;
        end
        checks++;
        if (sb_a.size() != 0 || ifa.busy !== 1'b0) begin
            failures++;
            $display("FAIL single_done got left=%0d busy=%b want 0/0", sb_a.size(), ifa.busy);
        end
        checks++;
        if (rr != 1) begin
            failures++;
            $display("FAIL single_ready_pulse got=%0d want=1", rr);
        end
        checks++;
        if (bcyc_a.size() != 4 || bcyc_a[bcyc_a.size()-1] - bcyc_a[0] != 3) begin
            failures++;
            $display("FAIL single_consecutive got n=%0d want 4 bytes over 4 cycles", bcyc_a.size());
        end
    endtask

    task automatic test_backpressure();
        bit seen = 0;
        bcyc_a.delete();
        exp_a(1, 24'h123456);
        @(posedge clk); #1;
        ifa.usb_ready = 1'b1;
        load_a(1, 24'h123456);
        for (int t = 0; t < 20 && !seen; t++) begin
            @(posedge clk); #1;
            if (ifa.usb_data_valid && ifa.usb_data_out == 8'h34) begin
                ifa.usb_ready = 1'b0;
                seen = 1;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL bp_reach_b1 got=timeout want byte 34");
        end
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            checks++;
            if (ifa.usb_data_out !== 8'h34 || ifa.usb_data_valid !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold got d=%h v=%b want 34/1", ifa.usb_data_out, ifa.usb_data_valid);
            end
        end
        @(posedge clk); #1;
        ifa.usb_ready = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (sb_a.size() == 0 && !ifa.busy) break;
        end
        checks++;
        if (sb_a.size() != 0 || ifa.busy !== 1'b0 || bcyc_a.size() != 4) begin
            failures++;
            $display("FAIL bp_once got left=%0d n=%0d want 0 left, 4 bytes", sb_a.size(), bcyc_a.size());
        end
        checks++;
        if (bcyc_a.size() == 4 && bcyc_a[3] - bcyc_a[0] != 6) begin
            failures++;
            $display("FAIL bp_span got=%0d want=6", bcyc_a[3] - bcyc_a[0]);
        end
    endtask

    task automatic test_burst_limit();
        int gaps[6] = '{4, 4, 4, 5, 5, 4};
        hcyc_a.delete();
        for (int k = 0; k < 4; k++) exp_a(2, wd(2, k));
        exp_a(0, wd(0, 0));
        for (int k = 4; k < 6; k++) exp_a(2, wd(2, k));
        @(posedge clk); #1;
        ifa.usb_ready = 1'b1;
        for (int k = 0; k < 6; k++) load_a(2, wd(2, k));
        load_a(0, wd(0, 0));
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (sb_a.size() == 0 && !ifa.busy) break;
        end
        checks++;
        if (sb_a.size() != 0 || ifa.busy !== 1'b0) begin
            failures++;
            $display("FAIL burst_done got left=%0d want=0", sb_a.size());
        end
        checks++;
        if (hcyc_a.size() != 7) begin
            failures++;
            $display("FAIL burst_headers got=%0d want=7", hcyc_a.size());
        end else begin
            for (int i = 1; i < 7; i++) begin
                checks++;
                if (hcyc_a[i] - hcyc_a[i-1] != gaps[i-1]) begin
                    failures++;
                    $display("FAIL burst_gap%0d got=%0d want=%0d", i, hcyc_a[i] - hcyc_a[i-1], gaps[i-1]);
                end
            end
        end
    endtask

    task automatic test_mid_burst_drop();
        int rr = 0;
        bcyc_a.delete();
        exp_a(3, wd(3, 0));
        @(posedge clk); #1;
        load_a(3, wd(3, 0));
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            rr += int'(ifa.req_ready[3]);
            if (sb_a.size() == 0 && !ifa.busy) break;
        end
        checks++;
        if (sb_a.size() != 0 || ifa.busy !== 1'b0 || bcyc_a.size() != 4 || rr != 1) begin
            failures++;
            $display("FAIL drop_word got left=%0d n=%0d rdy=%0d busy=%b want 0/4/1/0",
                     sb_a.size(), bcyc_a.size(), rr, ifa.busy);
        end
        // last grant is now 3, so 0 must beat 3
        exp_a(0, wd(0, 1));
        exp_a(3, wd(3, 1));
        @(posedge clk); #1;
        load_a(3, wd(3, 1));
        load_a(0, wd(0, 1));
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (sb_a.size() == 0 && !ifa.busy) break;
        end
        checks++;
        if (sb_a.size() != 0 || ifa.busy !== 1'b0) begin
            failures++;
            $display("FAIL drop_lastgrant got left=%0d want=0", sb_a.size());
        end
    endtask

    task automatic test_round_robin();
        hcyc_b.delete();
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < N; r++) exp_b(r, wd(r, k + 8));
        @(posedge clk); #1;
        ifb.usb_ready = 1'b1;
        for (int r = 0; r < N; r++)
            for (int k = 0; k < 2; k++) load_b(r, wd(r, k + 8));
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (sb_b.size() == 0 && !ifb.busy) break;
        end
        checks++;
        if (sb_b.size() != 0 || ifb.busy !== 1'b0 || hcyc_b.size() != 8) begin
            failures++;
            $display("FAIL rr_done got left=%0d hdrs=%0d want 0/8", sb_b.size(), hcyc_b.size());
        end else begin
            for (int i = 1; i < 8; i++) begin
                checks++;
                if (hcyc_b[i] - hcyc_b[i-1] != 5) begin
                    failures++;
                    $display("FAIL rr_gap%0d got=%0d want=5", i, hcyc_b[i] - hcyc_b[i-1]);
                end
            end
        end
    endtask

    task automatic test_ready_toggle();
        // last grant is 3 here, so requester 1 simply wins with a 2-word burst
        exp_a(1, wd(1, 5));
        exp_a(1, wd(1, 6));
        @(posedge clk); #1;
        load_a(1, wd(1, 5));
        load_a(1, wd(1, 6));
        for (int t = 0; t < 100; t++) begin
            @(posedge clk); #1;
            ifa.usb_ready = ~ifa.usb_ready;
            if (sb_a.size() == 0 && !ifa.busy) break;
        end
        checks++;
        if (sb_a.size() != 0 || ifa.busy !== 1'b0) begin
            failures++;
            $display("FAIL toggle_done got left=%0d busy=%b want 0/0", sb_a.size(), ifa.busy);
        end
        ifa.usb_ready = 1'b1;
    endtask

    task automatic test_reset_mid_word();
        logic [23:0] w = wd(2, 9);
        bit hit = 0;
        exp_a(2, w);
        @(posedge clk); #1;
        ifa.usb_ready = 1'b1;
        load_a(2, w);
        for (int t = 0; t < 20 && !hit; t++) begin
            @(posedge clk); #1;
            if (ifa.busy) hit = 1;
        end
        @(posedge clk); #1;
        checks++;
        if (!hit || ifa.usb_data_out !== w[23:16] || ifa.usb_data_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_reach_b2 got d=%h v=%b want %h/1", ifa.usb_data_out, ifa.usb_data_valid, w[23:16]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ifa.usb_data_valid !== 1'b0 || ifa.busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_async got v=%b busy=%b want 0/0", ifa.usb_data_valid, ifa.busy);
        end
        sb_a.delete();
        for (int r = 0; r < N; r++) head_a[r] = tail_a[r];
        for (int r = 0; r < N; r++) begin
            load_a(r, wd(r, 12));
            exp_a(r, wd(r, 12));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (sb_a.size() == 0 && !ifa.busy) break;
        end
        checks++;
        if (sb_a.size() != 0 || ifa.busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_restart got left=%0d want=0", sb_a.size());
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout got=hang want=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_word();
        test_backpressure();
        test_burst_limit();
        test_mid_burst_drop();
        test_round_robin();
        test_ready_toggle();
        test_reset_mid_word();
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
